// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: one req/ack data-memory transaction per load/store, with stall, strobes, load extend and timeout abort.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Load_1,
    input  logic        i_Store_1,
    input  logic        i_LoadUnsigned_1,
    input  logic [1:0]  i_LoadStoreWidth_2,
    input  logic [31:0] i_Addr_32,
    input  logic [31:0] i_StoreData_32,
    output logic        o_MemReq_1,
    output logic        o_MemWe_1,
    output logic [31:0] o_MemAddr_32,
    output logic [31:0] o_MemWdata_32,
    output logic [3:0]  o_MemWstrb_4,
    input  logic        i_MemAck_1,
    input  logic [31:0] i_MemRdata_32,
    output logic        o_Stall_1,
    output logic [31:0] o_LoadData_32,
    output logic        o_LoadValid_1,
    output logic        o_BusErr_1,
    output logic        o_Misalign_1
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       busy_width;
    logic [1:0]       busy_off;
    logic             busy_unsigned;

    logic        access;
    logic        misalign;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;
    logic [31:0] rd_byte_sh;
    logic [31:0] rd_half_sh;
    logic [31:0] load_ext;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Request decode, lane steering and load extraction
    always_comb begin
        access   = i_Load_1 | i_Store_1;
        misalign = 1'b0;
`ifdef MISALIGN_CHECK_EN
        case (i_LoadStoreWidth_2)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = i_Addr_32[0];
            default: misalign = |i_Addr_32[1:0];
        endcase
`endif
        issue = access & ~misalign;

        case (i_LoadStoreWidth_2)
            2'b00: begin
                wstrb_next = 4'b0001 << i_Addr_32[1:0];
                wdata_next = {4{i_StoreData_32[7:0]}};
            end
            2'b01: begin
                wstrb_next = 4'b0011 << {i_Addr_32[1], 1'b0};
                wdata_next = {2{i_StoreData_32[15:0]}};
            end
            default: begin
                wstrb_next = 4'b1111;
                wdata_next = i_StoreData_32;
            end
        endcase

        rd_byte_sh = i_MemRdata_32 >> {busy_off, 3'b000};
        rd_half_sh = i_MemRdata_32 >> {busy_off[1], 4'b0000};
        case (busy_width)
            2'b00:   load_ext = busy_unsigned ? {24'h0, rd_byte_sh[7:0]}
                                              : {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            2'b01:   load_ext = busy_unsigned ? {16'h0, rd_half_sh[15:0]}
                                              : {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
            default: load_ext = i_MemRdata_32;
        endcase
    end

    // Stall releases in the cycle the transaction ends so the pipeline advances on that edge
    assign o_Stall_1 = (state == IDLE) ? issue : (~i_MemAck_1 & ~timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            busy_width    <= 2'b00;
            busy_off      <= 2'b00;
            busy_unsigned <= 1'b0;
            o_MemReq_1    <= 1'b0;
            o_MemWe_1     <= 1'b0;
            o_MemAddr_32  <= 32'h0;
            o_MemWdata_32 <= 32'h0;
            o_MemWstrb_4  <= 4'h0;
            o_LoadData_32 <= 32'h0;
            o_LoadValid_1 <= 1'b0;
            o_BusErr_1    <= 1'b0;
            o_Misalign_1  <= 1'b0;
        end else begin
            o_LoadValid_1 <= 1'b0;
            o_BusErr_1    <= 1'b0;
            o_Misalign_1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state         <= BUSY;
                        cnt           <= '0;
                        o_MemReq_1    <= 1'b1;
                        o_MemWe_1     <= i_Store_1;
                        o_MemAddr_32  <= {i_Addr_32[31:2], 2'b00};
                        o_MemWdata_32 <= wdata_next;
                        o_MemWstrb_4  <= i_Store_1 ? wstrb_next : 4'b0000;
                        busy_width    <= i_LoadStoreWidth_2;
                        busy_off      <= i_Addr_32[1:0];
                        busy_unsigned <= i_LoadUnsigned_1;
                    end else begin
                        o_Misalign_1  <= access & misalign;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (i_MemAck_1) begin
                        state      <= IDLE;
                        o_MemReq_1 <= 1'b0;
                        if (!o_MemWe_1) begin
                            o_LoadData_32 <= load_ext;
                            o_LoadValid_1 <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        o_MemReq_1 <= 1'b0;
                        o_BusErr_1 <= 1'b1;
                        if (!o_MemWe_1) begin
                            o_LoadData_32 <= 32'h0;
                            o_LoadValid_1 <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
